control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hard-wired control unit that drives the datapath's control inputs, replacing the bench-driven T0–T5 sequence.
- Fetches each instruction and decodes the IR opcode supplied by the datapath.
- For three-register ALU instructions, issues the T0–T5 control-step sequence: fetch, operand Y-load, ALU-to-Z, and Z writeback.
- Sits directly upstream of the datapath and consumes its IR output.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- IR  in  32  instruction register contents from datapath. Fields: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- PCout, Zlowout, MDRout  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load enables.
- IncPC  out  1  ALU computes PC+1 into Z.
- Read  out  1  memory read strobe / MDR source select.
- Gra, Grb, Grc  out  1 each  select the Ra, Rb or Rc field for the datapath register select-and-encode logic.
- Rin, Rout  out  1 each  load / drive the selected general register.
- alu_op  out  5  operation code to ALU.
- Run  out  1  high while executing.
- illegal  out  1  sticky illegal-opcode flag.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, HALT.
- State is registered. All control outputs are decoded from the state register and IR only (Moore style); no output depends on mem_ready.
- Reset (synchronous, any state, mid-instruction included):
  - state <= RST; instr_count <= 0; illegal <= 0.
  - In RST every control output is 0, alu_op = 0 and Run = 0.
  - RST -> T0 on the next edge with Reset low.
- T0: PCout, MARin, IncPC, Zin. -> T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Holds in T1, outputs asserted, while mem_ready = 0.
  - -> T2 on an edge where mem_ready = 1.
  - Repeated PCin is harmless because Z is not reloaded during the wait.
- T2: MDRout, IRin. -> T3. IR is valid from T3 onward.
- ALU class is opcodes 00011..01011: add, sub, and, or, ror, rol, shr, shra, shl.
- T3 decode on IR[31:27]:
  - ALU: outputs Grb, Rout, Yin; -> T4.
  - 11010 (nop): no outputs; -> T0; instr_count increments.
  - 11011 (halt): no outputs; -> HALT.
  - Any other opcode: no outputs; -> HALT, illegal <= 1.
- T4: Grc, Rout, Zin, alu_op = IR[31:27]. -> T5.
- T5: Zlowout, Gra, Rin. -> T0; instr_count increments.
- alu_op is 0 in every state except T4.
- HALT:
  - All controls 0, Run = 0. Stays in HALT until Reset.
  - instr_count and illegal hold their values.
- Run = 1 in states T0–T5.
- instr_count wraps from 2^CNT_W−1 to 0. Halt and illegal instructions are not counted.
- No two bus drivers (PCout, Zlowout, MDRout, Rout) are ever high in the same cycle; the bench asserts this every cycle.
- IR changing outside T2 load is a datapath fault; behaviour is defined only by the IR value sampled in T3–T5.

Test Plan:
1. Reset high 2 cycles, then low -> all outputs 0 during reset and RST; T0 asserted (PCout=MARin=IncPC=Zin=1) on the following cycle.
2. mem_ready tied 1, IR = 0x2A2B8000 (and) -> T0..T5 in 6 consecutive cycles.
   - T3: Grb=Rout=Yin=1.
   - T4: Grc=Rout=Zin=1, alu_op=5'b00101.
   - T5: Zlowout=Gra=Rin=1.
   - instr_count 0->1 after T5; returns to T0.
3. mem_ready low 3 cycles in T1 -> Read=MDRin=1 held 4 cycles total; T2 follows the cycle mem_ready=1; no bus-driver overlap throughout.
4. IR opcode 11010 -> T0,T1,T2,T3,T0 with no controls in T3; instr_count increments once.
5. IR opcode 11011 -> HALT after T3, Run=0, illegal=0, outputs stay 0 for 10 cycles. IR opcode 11111 -> HALT with illegal=1, instr_count unchanged.
6. Reset asserted during T4 -> next cycle RST with all outputs 0 and instr_count=0. Separately, preload CNT_W=4 and run 16 nops -> count wraps to 0.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hard-wired control unit for the three-bus datapath. Fetches
//               each instruction (T0-T2), decodes the IR opcode in T3 and,
//               for three-register ALU instructions, issues the operand
//               Y-load, ALU-to-Z and Z writeback steps (T3-T5). Outputs are
//               decoded from the state register and IR only (Moore).
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [4:0]       alu_op,
  output logic             Run,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // State encoding
  localparam logic [2:0] c_RST  = 3'd0;
  localparam logic [2:0] c_T0   = 3'd1;
  localparam logic [2:0] c_T1   = 3'd2;
  localparam logic [2:0] c_T2   = 3'd3;
  localparam logic [2:0] c_T3   = 3'd4;
  localparam logic [2:0] c_T4   = 3'd5;
  localparam logic [2:0] c_T5   = 3'd6;
  localparam logic [2:0] c_HALT = 3'd7;

  // Opcode boundaries of interest
  localparam logic [4:0] c_OP_ALU_LO = 5'b00011;
  localparam logic [4:0] c_OP_ALU_HI = 5'b01011;
  localparam logic [4:0] c_OP_NOP    = 5'b11010;
  localparam logic [4:0] c_OP_HALT   = 5'b11011;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_illegal;

  logic [4:0]       w_opcode;
  logic             w_is_alu;
  logic             w_is_nop;
  logic             w_is_halt;
  logic             w_unused_ir;

  // Register fields Ra/Rb/Rc are consumed by the datapath's select logic via
  // Gra/Grb/Grc; this block only needs the opcode.
  assign w_opcode    = IR[31:27];
  assign w_unused_ir = ^IR[26:0];
  assign w_is_alu    = (w_opcode >= c_OP_ALU_LO) && (w_opcode <= c_OP_ALU_HI);
  assign w_is_nop    = (w_opcode == c_OP_NOP);
  assign w_is_halt   = (w_opcode == c_OP_HALT);

  // Sequencer state, retired-instruction counter and sticky illegal flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= c_RST;
      r_instr_count <= '0;
      r_illegal     <= 1'b0;
    end else begin
      case (r_state)
        c_RST: r_state <= c_T0;
        c_T0:  r_state <= c_T1;
        // Wait for memory; Z is not reloaded here so repeated PCin is benign
        c_T1:  if (mem_ready) r_state <= c_T2;
        c_T2:  r_state <= c_T3;
        c_T3: begin
          if (w_is_alu) begin
            r_state <= c_T4;
          end else if (w_is_nop) begin
            r_state       <= c_T0;
            r_instr_count <= r_instr_count + 1'b1;
          end else if (w_is_halt) begin
            r_state <= c_HALT;
          end else begin
            r_state   <= c_HALT;
            r_illegal <= 1'b1;
          end
        end
        c_T4:  r_state <= c_T5;
        c_T5: begin
          r_state       <= c_T0;
          r_instr_count <= r_instr_count + 1'b1;
        end
        c_HALT: r_state <= c_HALT;
        default: r_state <= c_RST;
      endcase
    end
  end

  // Moore control decode from state and IR
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    alu_op  = 5'd0;
    Run     = 1'b0;
    case (r_state)
      c_T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      c_T1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      c_T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      c_T3: begin
        Run = 1'b1;
        if (w_is_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      c_T4: begin
        Run    = 1'b1;
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = w_opcode;
      end
      c_T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      default: begin
        Run = 1'b0;
      end
    endcase
  end

  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer with
//               hand-computed expected control words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  localparam int CNT_W = 4;

  // Control word bit positions, MSB first
  localparam logic [16:0] B_PCOUT   = 17'h10000;
  localparam logic [16:0] B_ZLOWOUT = 17'h08000;
  localparam logic [16:0] B_MDROUT  = 17'h04000;
  localparam logic [16:0] B_MARIN   = 17'h02000;
  localparam logic [16:0] B_ZIN     = 17'h01000;
  localparam logic [16:0] B_PCIN    = 17'h00800;
  localparam logic [16:0] B_MDRIN   = 17'h00400;
  localparam logic [16:0] B_IRIN    = 17'h00200;
  localparam logic [16:0] B_YIN     = 17'h00100;
  localparam logic [16:0] B_INCPC   = 17'h00080;
  localparam logic [16:0] B_READ    = 17'h00040;
  localparam logic [16:0] B_GRA     = 17'h00020;
  localparam logic [16:0] B_GRB     = 17'h00010;
  localparam logic [16:0] B_GRC     = 17'h00008;
  localparam logic [16:0] B_RIN     = 17'h00004;
  localparam logic [16:0] B_ROUT    = 17'h00002;
  localparam logic [16:0] B_RUN     = 17'h00001;

  localparam logic [16:0] E_IDLE  = 17'h0;
  localparam logic [16:0] E_T0    = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [16:0] E_T1    = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [16:0] E_T2    = B_MDROUT | B_IRIN | B_RUN;
  localparam logic [16:0] E_T3ALU = B_GRB | B_ROUT | B_YIN | B_RUN;
  localparam logic [16:0] E_T3NO  = B_RUN;
  localparam logic [16:0] E_T4    = B_GRC | B_ROUT | B_ZIN | B_RUN;
  localparam logic [16:0] E_T5    = B_ZLOWOUT | B_GRA | B_RIN | B_RUN;

  localparam logic [31:0] IR_AND  = 32'h2A2B8000;
  localparam logic [31:0] IR_ADD  = 32'h18000000;
  localparam logic [31:0] IR_SHL  = 32'h58000000;
  localparam logic [31:0] IR_BAD0 = 32'h60000000;
  localparam logic [31:0] IR_BAD1 = 32'h10000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [31:0]      IR;
  logic             mem_ready;
  logic             PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic             IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, illegal;
  logic [4:0]       alu_op;
  logic [CNT_W-1:0] instr_count;
  logic [16:0]      ctl;

  int vectors     = 0;
  int miscompares = 0;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  assign ctl = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run};

  // At most one bus driver active in any cycle
  always @(negedge Clock) begin
    vectors++;
    assert ($countones({PCout, Zlowout, MDRout, Rout}) <= 1) else begin
      miscompares++;
      $error("FAIL bus_overlap observed=%b expected=at most one driver",
             {PCout, Zlowout, MDRout, Rout});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step one clock and sample 1 time unit after the active edge
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // From T0: step through T1 and T2 with memory ready
  task automatic fetch();
    tick(); chk("fetch_T1", 32'(ctl), 32'(E_T1));
    tick(); chk("fetch_T2", 32'(ctl), 32'(E_T2));
  endtask

  initial begin
    Reset = 1'b1; IR = 32'h0; mem_ready = 1'b1;

    // 1. Reset and release
    tick(); chk("rst_ctl0", 32'(ctl), 32'(E_IDLE));
    tick(); chk("rst_ctl1", 32'(ctl), 32'(E_IDLE));
    chk("rst_alu", 32'(alu_op), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    Reset = 1'b0;
    chk("rststate_ctl", 32'(ctl), 32'(E_IDLE));
    tick(); chk("first_T0", 32'(ctl), 32'(E_T0));

    // 2. AND instruction, six-cycle sequence
    IR = IR_AND;
    fetch();
    tick(); chk("and_T3", 32'(ctl), 32'(E_T3ALU));
    chk("and_T3_alu", 32'(alu_op), 32'd0);
    tick(); chk("and_T4", 32'(ctl), 32'(E_T4));
    chk("and_T4_alu", 32'(alu_op), 32'h05);
    tick(); chk("and_T5", 32'(ctl), 32'(E_T5));
    chk("and_T5_cnt", 32'(instr_count), 32'd0);
    tick(); chk("and_T0", 32'(ctl), 32'(E_T0));
    chk("and_cnt", 32'(instr_count), 32'd1);

    // 3. Memory wait: three low edges while in T1
    mem_ready = 1'b0;
    tick(); chk("wait_T1_0", 32'(ctl), 32'(E_T1));
    tick(); chk("wait_T1_1", 32'(ctl), 32'(E_T1));
    tick(); chk("wait_T1_2", 32'(ctl), 32'(E_T1));
    tick(); chk("wait_T1_3", 32'(ctl), 32'(E_T1));
    mem_ready = 1'b1;
    tick(); chk("wait_T2", 32'(ctl), 32'(E_T2));
    tick(); chk("wait_T3", 32'(ctl), 32'(E_T3ALU));
    tick(); tick(); tick();
    chk("wait_T0", 32'(ctl), 32'(E_T0));
    chk("wait_cnt", 32'(instr_count), 32'd2);

    // 4. NOP
    IR = IR_NOP;
    fetch();
    tick(); chk("nop_T3", 32'(ctl), 32'(E_T3NO));
    tick(); chk("nop_T0", 32'(ctl), 32'(E_T0));
    chk("nop_cnt", 32'(instr_count), 32'd3);

    // 5a. HALT
    IR = IR_HALT;
    fetch();
    tick(); chk("halt_T3", 32'(ctl), 32'(E_T3NO));
    for (int i = 0; i < 10; i++) begin
      tick(); chk("halt_ctl", 32'(ctl), 32'(E_IDLE));
    end
    chk("halt_ill", 32'(illegal), 32'd0);
    chk("halt_cnt", 32'(instr_count), 32'd3);

    // 5b. Illegal opcode after one counted NOP
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("rst2_cnt", 32'(instr_count), 32'd0);
    tick(); IR = IR_NOP;
    fetch(); tick(); tick();
    chk("ill_pre_cnt", 32'(instr_count), 32'd1);
    IR = IR_ILL;
    fetch();
    tick(); chk("ill_T3", 32'(ctl), 32'(E_T3NO));
    chk("ill_T3_flag", 32'(illegal), 32'd0);
    tick(); chk("ill_halt_ctl", 32'(ctl), 32'(E_IDLE));
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_cnt", 32'(instr_count), 32'd1);
    tick(); chk("ill_sticky", 32'(illegal), 32'd1);

    // Opcode boundaries: lowest/highest ALU, just above the ALU range
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("rst3_ill", 32'(illegal), 32'd0);
    tick(); IR = IR_SHL;
    fetch();
    tick(); chk("shl_T3", 32'(ctl), 32'(E_T3ALU));
    tick(); chk("shl_alu", 32'(alu_op), 32'h0B);
    tick(); tick(); IR = IR_ADD;
    fetch();
    tick(); chk("add_T3", 32'(ctl), 32'(E_T3ALU));
    tick(); chk("add_alu", 32'(alu_op), 32'h03);
    tick(); tick(); IR = IR_BAD0;
    fetch();
    tick(); chk("op0c_T3", 32'(ctl), 32'(E_T3NO));
    tick(); chk("op0c_ill", 32'(illegal), 32'd1);
    chk("op0c_cnt", 32'(instr_count), 32'd2);

    // Just below the ALU range
    Reset = 1'b1; tick(); Reset = 1'b0;
    tick(); IR = IR_BAD1;
    fetch();
    tick(); chk("op02_T3", 32'(ctl), 32'(E_T3NO));
    tick(); chk("op02_ill", 32'(illegal), 32'd1);

    // 6a. Reset in T4 after one retired instruction
    Reset = 1'b1; tick(); Reset = 1'b0;
    tick(); IR = IR_AND;
    fetch(); tick(); tick(); tick(); tick();
    chk("midrst_pre_cnt", 32'(instr_count), 32'd1);
    fetch(); tick(); tick();
    chk("midrst_T4", 32'(ctl), 32'(E_T4));
    Reset = 1'b1;
    tick(); chk("midrst_ctl", 32'(ctl), 32'(E_IDLE));
    chk("midrst_alu", 32'(alu_op), 32'd0);
    chk("midrst_cnt", 32'(instr_count), 32'd0);

    // 6b. Counter wrap with 16 NOPs on a 4-bit counter
    Reset = 1'b0;
    tick(); IR = IR_NOP;
    for (int n = 0; n < 15; n++) begin
      tick(); tick(); tick(); tick();
    end
    chk("wrap_cnt15", 32'(instr_count), 32'd15);
    tick(); tick(); tick(); tick();
    chk("wrap_cnt0", 32'(instr_count), 32'd0);
    chk("wrap_T0", 32'(ctl), 32'(E_T0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
